// File: rtl/bc_pkg.sv
// bc_pkg: command-word fields, opcode and fetch-state types shared by the PWM generator
package bc_pkg;
  typedef enum logic [1:0] {BC_SET_DUTY, BC_SET_PERIOD, BC_STOP, BC_RSVD} bc_op_e;
  localparam int BC_OP_MSB  = 15;
  localparam int BC_OP_LSB  = 14;
  localparam int BC_CH_BIT  = 13;
  localparam int BC_DIR_BIT = 12;
  localparam int BC_VAL_MSB = 11;
  typedef enum logic [1:0] {IDLE, REQ, CAPT, EXEC} fetch_state_e;
  function automatic bc_op_e bc_op(input logic [15:0] w);
    return bc_op_e'(w[BC_OP_MSB:BC_OP_LSB]);
  endfunction
endpackage

// File: rtl/bc_pwm_channel.sv
// bc_pwm_channel: one PWM channel with pending/active duty and direction and a registered compare
module bc_pwm_channel #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             wrap_i,
  input  logic             load_i,
  input  logic             stop_i,
  input  logic [CNT_W-1:0] duty_i,
  input  logic             dir_i,
  output logic             pwm_o,
  output logic             dir_o
);
  logic en_q, en_d, pdir_q, pdir_d, adir_q, adir_d, pwm_q, pwm_d, copy;
  logic [CNT_W-1:0] pduty_q, pduty_d, aduty_q, aduty_d;
  // Next state; the compare uses next-cycle counter and duty so pwm_o tracks en && cnt < duty exactly
  always_comb begin
    copy    = wrap_i || (load_i && !en_q);
    en_d    = stop_i ? 1'b0 : load_i || en_q;
    pduty_d = stop_i ? '0 : load_i ? duty_i : pduty_q;
    pdir_d  = load_i ? dir_i : pdir_q;
    aduty_d = stop_i ? '0 : copy ? pduty_d : aduty_q;
    adir_d  = copy ? pdir_d : adir_q;
    pwm_d   = en_d && cnt_i < aduty_d;
  end
  // Channel registers
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q    <= 1'b0;
      pduty_q <= '0;
      aduty_q <= '0;
      pdir_q  <= 1'b1;
      adir_q  <= 1'b1;
      pwm_q   <= 1'b0;
    end else begin
      en_q    <= en_d;
      pduty_q <= pduty_d;
      aduty_q <= aduty_d;
      pdir_q  <= pdir_d;
      adir_q  <= adir_d;
      pwm_q   <= pwm_d;
    end
  end
  assign pwm_o = pwm_q;
  assign dir_o = adir_q;
endmodule

// File: rtl/bc_pwm_gen.sv
// bc_pwm_gen: fetches command words from a FIFO and drives two PWM channels with direction bits
module bc_pwm_gen
  import bc_pkg::*;
#(
  parameter int CNT_W          = 12,
  parameter int PRESCALE       = 100,
  parameter int DEFAULT_PERIOD = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic [15:0] fifo_dout,
  output logic [1:0]  pwm_out,
  output logic [1:0]  dir_out,
  output logic        cmd_err,
  output logic [15:0] cmd_count
);
  localparam int PSC_W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  fetch_state_e state_q;
  logic rd_en_q, err_q, tick, wrap, exec;
  logic [15:0] word_q, count_q;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d, pend_period_q, pend_period_d, cap_val, val;
  logic [1:0] load, stop;
  bc_op_e op;
  assign cap_val = CNT_W'(fifo_dout[BC_VAL_MSB:0]);
  assign val     = CNT_W'(word_q[BC_VAL_MSB:0]);
  assign op      = bc_op(word_q);
  assign exec    = state_q == EXEC;
  assign load    = {2{exec && op == BC_SET_DUTY}} & {word_q[BC_CH_BIT], !word_q[BC_CH_BIT]};
  assign stop    = {2{exec && op == BC_STOP}} & {word_q[BC_CH_BIT], !word_q[BC_CH_BIT]};
  // Prescaler, shared counter and period; a period written in EXEC on the wrap cycle is the one taken
  always_comb begin
    tick          = psc_q == PSC_W'(PRESCALE - 1);
    psc_d         = tick ? '0 : psc_q + 1'b1;
    wrap          = tick && cnt_q == period_q - 1'b1;
    cnt_d         = wrap ? '0 : cnt_q + CNT_W'(tick);
    pend_period_d = exec && !err_q && op == BC_SET_PERIOD ? val : pend_period_q;
    period_d      = wrap ? pend_period_d : period_q;
  end
  // Timebase registers
  always_ff @(posedge clk) begin
    if (rst) begin
      psc_q         <= '0;
      cnt_q         <= '0;
      period_q      <= CNT_W'(DEFAULT_PERIOD);
      pend_period_q <= CNT_W'(DEFAULT_PERIOD);
    end else begin
      psc_q         <= psc_d;
      cnt_q         <= cnt_d;
      period_q      <= period_d;
      pend_period_q <= pend_period_d;
    end
  end
  // Fetch FSM; rejection is decided while capturing so cmd_err is high exactly during EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rd_en_q <= 1'b0;
      word_q  <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE:    state_q <= fifo_empty ? IDLE : REQ;
        REQ:     state_q <= CAPT;
        CAPT:    state_q <= EXEC;
        default: state_q <= IDLE;
      endcase
      rd_en_q <= state_q == IDLE && !fifo_empty;
      if (state_q == CAPT) word_q <= fifo_dout;
      err_q   <= state_q == CAPT && (bc_op(fifo_dout) == BC_RSVD || (bc_op(fifo_dout) == BC_SET_PERIOD && cap_val < CNT_W'(2)));
      if (exec && !err_q) count_q <= count_q + 1'b1;
    end
  end
  for (genvar g = 0; g < 2; g++) begin : g_ch
    bc_pwm_channel #(.CNT_W(CNT_W)) u_ch (
      .clk    (clk),
      .rst    (rst),
      .cnt_i  (cnt_d),
      .wrap_i (wrap),
      .load_i (load[g]),
      .stop_i (stop[g]),
      .duty_i (val),
      .dir_i  (word_q[BC_DIR_BIT]),
      .pwm_o  (pwm_out[g]),
      .dir_o  (dir_out[g])
    );
  end
  assign fifo_rd_en = rd_en_q;
  assign cmd_err    = err_q;
  assign cmd_count  = count_q;
endmodule

// File: tb/tb_bc_pwm_gen.sv
// tb_bc_pwm_gen: scenario tasks and random traffic checked against a behavioural model of the generator
module tb_bc_pwm_gen;
  logic clk = 0, rst = 1, fifo_empty = 1, fifo_rd_en, cmd_err;
  logic [15:0] fifo_dout = 0, cmd_count;
  logic [1:0] pwm_out, dir_out;
  always #5 clk = ~clk;
  bc_pwm_gen #(.CNT_W(12), .PRESCALE(1), .DEFAULT_PERIOD(10)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
    .pwm_out(pwm_out), .dir_out(dir_out), .cmd_err(cmd_err), .cmd_count(cmd_count)
  );
  localparam logic [21:0] RST_VEC = {1'b0, 1'b0, 2'b00, 2'b11, 16'h0000};
  wire [21:0] obs = {fifo_rd_en, cmd_err, pwm_out, dir_out, cmd_count};
  logic [15:0] q[$];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int m_ph, m_cnt, m_per, m_pper, m_count;
  int m_act[2], m_pend[2];
  bit m_en[2], m_adir[2], m_pdir[2];
  logic [15:0] m_word;
  function automatic bit rejected(logic [15:0] w);
    return w[15:14] == 2'd3 || (w[15:14] == 2'd1 && w[11:0] < 12'd2);
  endfunction
  task automatic model_reset();
    m_ph = 0; m_cnt = 0; m_per = 10; m_pper = 10; m_count = 0; m_word = 0;
    for (int c = 0; c < 2; c++) begin
      m_act[c] = 0; m_pend[c] = 0; m_en[c] = 0; m_adir[c] = 1; m_pdir[c] = 1;
    end
  endtask
  task automatic model_edge(bit r, bit e, logic [15:0] d);
    int op, ch, v;
    bit wrap;
    if (r) begin
      model_reset();
      return;
    end
    wrap = m_cnt == m_per - 1;
    if (m_ph == 3 && !rejected(m_word)) begin
      op = int'(m_word[15:14]); ch = int'(m_word[13]); v = int'(m_word[11:0]);
      if (op == 0) begin
        m_pend[ch] = v; m_pdir[ch] = m_word[12];
        if (!m_en[ch]) begin m_act[ch] = v; m_adir[ch] = m_word[12]; end
        m_en[ch] = 1;
      end else if (op == 1) m_pper = v;
      else begin m_en[ch] = 0; m_act[ch] = 0; m_pend[ch] = 0; end
      m_count = (m_count + 1) % 65536;
    end
    if (m_ph == 2) m_word = d;
    m_cnt = wrap ? 0 : m_cnt + 1;
    if (wrap) begin
      m_per = m_pper;
      for (int c = 0; c < 2; c++) begin m_act[c] = m_pend[c]; m_adir[c] = m_pdir[c]; end
    end
    m_ph = m_ph == 0 ? (e ? 0 : 1) : (m_ph + 1) % 4;
  endtask
  function automatic logic [21:0] exp_vec();
    logic [1:0] p;
    for (int c = 0; c < 2; c++) p[c] = m_en[c] && m_cnt < m_act[c];
    return {m_ph == 1, m_ph == 3 && rejected(m_word), p, m_adir[1], m_adir[0], 16'(m_count)};
  endfunction
  task automatic step();
    bit r, e, rd;
    logic [15:0] d;
    r = rst; e = fifo_empty; d = fifo_dout; rd = fifo_rd_en === 1'b1;
    @(posedge clk);
    #1;
    model_edge(r, e, d);
    if (rd && q.size() > 0) fifo_dout = q.pop_front();
    fifo_empty = q.size() == 0;
    cyc++;
  endtask
  task automatic push(logic [15:0] w);
    q.push_back(w);
    fifo_empty = 0;
  endtask
  task automatic test_reset();
    bit saw_rd = 0;
    model_reset();
    rst = 1;
    repeat (3) step();
    n_cmp++; if (obs !== RST_VEC) begin n_bad++; $display("FAIL reset_values: got %h want %h", obs, RST_VEC); end
    rst = 0;
    repeat (20) begin
      step();
      saw_rd |= fifo_rd_en;
      n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL reset_idle cyc=%0d: got %h want %h", cyc, obs, exp_vec()); end
    end
    n_cmp++; if (saw_rd) begin n_bad++; $display("FAIL reset_no_pop: got rd_en=1 want never"); end
    n_cmp++; if (obs !== RST_VEC) begin n_bad++; $display("FAIL reset_idle_end: got %h want %h", obs, RST_VEC); end
  endtask
  task automatic test_duty();
    int pops = 0, hi = 0;
    push(16'h1003);
    for (int i = 0; i < 40; i++) begin
      step();
      pops += int'(fifo_rd_en);
      if (i >= 20) hi += int'(pwm_out[0]);
      n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL duty cyc=%0d: got %h want %h", cyc, obs, exp_vec()); end
    end
    n_cmp++; if (pops != 1) begin n_bad++; $display("FAIL duty_pops: got %0d want 1", pops); end
    n_cmp++; if (hi != 6) begin n_bad++; $display("FAIL duty_high: got %0d want 6", hi); end
    n_cmp++; if (dir_out[0] !== 1'b1 || cmd_count !== 16'd1) begin n_bad++; $display("FAIL duty_dir_count: got dir=%b cnt=%0d want 1 1", dir_out[0], cmd_count); end
  endtask
  task automatic test_duty_update();
    int hi = 0, guard = 0;
    while (m_cnt != 4 && guard < 20) begin step(); guard++; end
    n_cmp++; if (m_cnt != 4) begin n_bad++; $display("FAIL update_align: got cnt=%0d want 4", m_cnt); end
    push(16'h0007);
    for (int i = 0; i < 40; i++) begin
      step();
      if (i >= 20) hi += int'(pwm_out[0]);
      n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL update cyc=%0d: got %h want %h", cyc, obs, exp_vec()); end
    end
    n_cmp++; if (hi != 14) begin n_bad++; $display("FAIL update_high: got %0d want 14", hi); end
    n_cmp++; if (dir_out[0] !== 1'b0 || cmd_count !== 16'd2) begin n_bad++; $display("FAIL update_dir_count: got dir=%b cnt=%0d want 0 2", dir_out[0], cmd_count); end
  endtask
  task automatic test_reject();
    logic [15:0] words[2] = '{16'h4001, 16'hC000};
    int hi = 0;
    foreach (words[k]) begin
      int errs = 0;
      push(words[k]);
      repeat (12) begin
        step();
        errs += int'(cmd_err);
        n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL reject cyc=%0d: got %h want %h", cyc, obs, exp_vec()); end
      end
      n_cmp++; if (errs != 1) begin n_bad++; $display("FAIL reject_pulse %h: got %0d want 1", words[k], errs); end
      n_cmp++; if (cmd_count !== 16'd2) begin n_bad++; $display("FAIL reject_count %h: got %0d want 2", words[k], cmd_count); end
    end
    repeat (20) begin step(); hi += int'(pwm_out[0]); end
    n_cmp++; if (hi != 14) begin n_bad++; $display("FAIL reject_period: got %0d want 14", hi); end
  endtask
  task automatic test_full_and_stop();
    int hi = 0;
    push(16'h300F);
    repeat (10) begin
      step();
      n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL full cyc=%0d: got %h want %h", cyc, obs, exp_vec()); end
    end
    repeat (20) begin step(); hi += int'(pwm_out[1]); end
    n_cmp++; if (hi != 20) begin n_bad++; $display("FAIL full_const: got %0d want 20", hi); end
    push(16'hA000);
    repeat (8) begin
      step();
      n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL stop cyc=%0d: got %h want %h", cyc, obs, exp_vec()); end
    end
    hi = 0;
    repeat (12) begin step(); hi += int'(pwm_out[1]); end
    n_cmp++; if (hi != 0) begin n_bad++; $display("FAIL stop_zero: got %0d want 0", hi); end
    n_cmp++; if (dir_out[1] !== 1'b1 || cmd_count !== 16'd4) begin n_bad++; $display("FAIL stop_dir_count: got dir=%b cnt=%0d want 1 4", dir_out[1], cmd_count); end
  endtask
  task automatic test_back_to_back();
    int at[$];
    push(16'h0002); push(16'h2005); push(16'h4008);
    for (int i = 0; i < 24; i++) begin
      step();
      if (fifo_rd_en) at.push_back(i);
      n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL b2b cyc=%0d: got %h want %h", cyc, obs, exp_vec()); end
    end
    n_cmp++; if (at.size() != 3) begin n_bad++; $display("FAIL b2b_pops: got %0d want 3", at.size()); end
    else begin
      n_cmp++; if (at[1] - at[0] != 4 || at[2] - at[1] != 4) begin n_bad++; $display("FAIL b2b_gap: got %0d,%0d want 4,4", at[1] - at[0], at[2] - at[1]); end
    end
  endtask
  task automatic test_reset_capt();
    int guard = 0;
    push(16'h1009);
    while (m_ph != 2 && guard < 8) begin step(); guard++; end
    n_cmp++; if (m_ph != 2) begin n_bad++; $display("FAIL rstcapt_reach: got phase %0d want 2", m_ph); end
    rst = 1;
    step();
    n_cmp++; if (obs !== RST_VEC) begin n_bad++; $display("FAIL rstcapt_values: got %h want %h", obs, RST_VEC); end
    rst = 0;
    repeat (20) begin
      step();
      n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL rstcapt cyc=%0d: got %h want %h", cyc, obs, exp_vec()); end
    end
    n_cmp++; if (obs !== RST_VEC) begin n_bad++; $display("FAIL rstcapt_discard: got %h want %h", obs, RST_VEC); end
  endtask
  task automatic test_random();
    repeat (400) begin
      if (q.size() < 3 && $urandom_range(0, 5) == 0)
        push({2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 12'($urandom_range(0, 14))});
      step();
      n_cmp++; if (obs !== exp_vec()) begin n_bad++; $display("FAIL random cyc=%0d: got %h want %h", cyc, obs, exp_vec()); end
      n_cmp++; if (fifo_rd_en && fifo_empty) begin n_bad++; $display("FAIL random_pop_empty cyc=%0d: got rd_en=1 want 0", cyc); end
    end
  endtask
  initial begin
    test_reset();
    test_duty();
    test_duty_update();
    test_reject();
    test_full_and_stop();
    test_back_to_back();
    test_reset_capt();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
